// File: rtl/main_control_sequencer_if.sv
// Bus bundle between the main control sequencer and the rest of the EDSAC main control:
// run/stop controls, order decode inputs, and the timing/stage outputs.
interface main_control_sequencer_if #(
   parameter int unsigned EXEC_W = 5
) ();
   logic              run;
   logic              stop_req;
   logic              single_step;
   logic [3:0]        order_slot;
   logic              need_opnd;
   logic [3:0]        opnd_slot;
   logic [EXEC_W-1:0] exec_len;
   logic              halt_order;
   logic [5:0]        digit;
   logic              digit_last;
   logic [3:0]        minor_idx;
   logic              stage_fetch;
   logic              stage_opnd;
   logic              stage_exec;
   logic              busy;
   logic              halted;
   logic              order_done;

   modport master (
      output run, stop_req, single_step, order_slot, need_opnd, opnd_slot, exec_len, halt_order,
      input  digit, digit_last, minor_idx, stage_fetch, stage_opnd, stage_exec, busy, halted,
             order_done
   );

   modport slave (
      input  run, stop_req, single_step, order_slot, need_opnd, opnd_slot, exec_len, halt_order,
      output digit, digit_last, minor_idx, stage_fetch, stage_opnd, stage_exec, busy, halted,
             order_done
   );
endinterface

// File: rtl/main_control_sequencer.sv
// Minor/major-cycle timing and order-stage sequencer for the EDSAC main control.
// Counters run freely; the stage FSM moves only on minor-cycle boundaries.
module main_control_sequencer #(
   parameter int unsigned DIGITS = 36,
   parameter int unsigned MINORS = 16,
   parameter int unsigned EXEC_W = 5
) (
   input logic                     clk,
   input logic                     rst,
   main_control_sequencer_if.slave bus
);

   localparam logic [5:0]        DIG_LAST = 6'(DIGITS - 1);
   localparam logic [5:0]        DIG_PRE  = 6'(DIGITS - 2);
   localparam logic [3:0]        MIN_LAST = 4'(MINORS - 1);
   localparam logic [EXEC_W-1:0] CNT_ONE  = EXEC_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_ORD,
      ST_FETCH,
      ST_WAIT_OPND,
      ST_OPND,
      ST_EXEC,
      ST_HALTED
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        digit_q, digit_d;
   logic [3:0]        minor_q, minor_d;
   logic [EXEC_W-1:0] cnt_q, cnt_d;
   logic              stop_q, stop_d;
   logic              restart_q, restart_d;
   logic              run_q;
   logic              need_q, need_d;
   logic [3:0]        opnd_slot_q, opnd_slot_d;
   logic [EXEC_W-1:0] exec_len_q, exec_len_d;
   logic              halt_q, halt_d;
   logic              digit_last_q, fetch_q, opnd_q, exec_q, busy_q, halted_q, done_q;

   logic              bnd;
   logic [3:0]        nxt;
   logic              ord_hit;
   logic [EXEC_W-1:0] len_in, len_r;
   state_t            to_wait;

   always_comb begin
      bnd     = (digit_q == DIG_LAST);
      nxt     = (minor_q == MIN_LAST) ? '0 : minor_q + 4'd1;
      digit_d = bnd ? '0 : digit_q + 6'd1;
      minor_d = bnd ? nxt : minor_q;
      ord_hit = (nxt == bus.order_slot);
      // Entering the order wait on the boundary just before the order's slot goes straight to FETCH.
      to_wait = ord_hit ? ST_FETCH : ST_WAIT_ORD;
      len_in  = (bus.exec_len == '0) ? CNT_ONE : bus.exec_len;
      len_r   = (exec_len_q == '0) ? CNT_ONE : exec_len_q;

      state_d     = state_q;
      cnt_d       = cnt_q;
      stop_d      = stop_q | bus.stop_req;
      restart_d   = 1'b0;
      need_d      = need_q;
      opnd_slot_d = opnd_slot_q;
      exec_len_d  = exec_len_q;
      halt_d      = halt_q;

      unique case (state_q)
         ST_IDLE: begin
            stop_d = 1'b0;
            if (bnd && bus.run) state_d = to_wait;
         end
         ST_WAIT_ORD: begin
            if (bnd && ord_hit) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (bnd) begin
               need_d      = bus.need_opnd;
               opnd_slot_d = bus.opnd_slot;
               exec_len_d  = bus.exec_len;
               halt_d      = bus.halt_order;
               if (bus.need_opnd) begin
                  state_d = (nxt == bus.opnd_slot) ? ST_OPND : ST_WAIT_OPND;
               end else begin
                  state_d = ST_EXEC;
                  cnt_d   = len_in;
               end
            end
         end
         ST_WAIT_OPND: begin
            if (bnd && (nxt == opnd_slot_q)) state_d = ST_OPND;
         end
         ST_OPND: begin
            if (bnd) begin
               state_d = ST_EXEC;
               cnt_d   = len_r;
            end
         end
         ST_EXEC: begin
            if (bnd) begin
               if (cnt_q <= CNT_ONE) begin
                  cnt_d  = '0;
                  stop_d = 1'b0;
                  if (halt_q)                                       state_d = ST_HALTED;
                  else if (stop_q | bus.stop_req | bus.single_step) state_d = ST_IDLE;
                  else                                              state_d = to_wait;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         ST_HALTED: begin
            stop_d    = 1'b0;
            restart_d = restart_q | (bus.run & ~run_q);
            if (bnd && restart_d) begin
               restart_d = 1'b0;
               state_d   = to_wait;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         digit_q      <= '0;
         minor_q      <= '0;
         cnt_q        <= '0;
         stop_q       <= 1'b0;
         restart_q    <= 1'b0;
         run_q        <= 1'b0;
         need_q       <= 1'b0;
         opnd_slot_q  <= '0;
         exec_len_q   <= '0;
         halt_q       <= 1'b0;
         digit_last_q <= 1'b0;
         fetch_q      <= 1'b0;
         opnd_q       <= 1'b0;
         exec_q       <= 1'b0;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_q      <= digit_d;
         minor_q      <= minor_d;
         cnt_q        <= cnt_d;
         stop_q       <= stop_d;
         restart_q    <= restart_d;
         run_q        <= bus.run;
         need_q       <= need_d;
         opnd_slot_q  <= opnd_slot_d;
         exec_len_q   <= exec_len_d;
         halt_q       <= halt_d;
         digit_last_q <= (digit_d == DIG_LAST);
         fetch_q      <= (state_d == ST_FETCH);
         opnd_q       <= (state_d == ST_OPND);
         exec_q       <= (state_d == ST_EXEC);
         busy_q       <= (state_d != ST_IDLE) && (state_d != ST_HALTED);
         halted_q     <= (state_d == ST_HALTED);
         // The last digit of the final execute minor follows the edge leaving digit DIGITS-2.
         done_q       <= (state_q == ST_EXEC) && (cnt_q == CNT_ONE) && (digit_q == DIG_PRE);
      end
   end

   assign bus.digit       = digit_q;
   assign bus.digit_last  = digit_last_q;
   assign bus.minor_idx   = minor_q;
   assign bus.stage_fetch = fetch_q;
   assign bus.stage_opnd  = opnd_q;
   assign bus.stage_exec  = exec_q;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;
   assign bus.order_done  = done_q;

endmodule

// File: tb/tb_main_control_sequencer.sv
// Bench for main_control_sequencer: each order is modelled as a schedule of minor cycles
// computed from slot arithmetic, and every clock is compared against that schedule.
module tb_main_control_sequencer;

   typedef enum int {X_IDLE, X_WAIT, X_FETCH, X_OPND, X_EXEC, X_HALT} xs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ncmp = 0;
   int   nfail = 0;
   int   cur = 0;
   int   after;
   int   w;

   main_control_sequencer_if #(.EXEC_W(5)) bus ();

   main_control_sequencer #(.DIGITS(36), .MINORS(16), .EXEC_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s minor#%0d got=%h exp=%h", tag, cur, got, exp);
      end
   endtask

   function automatic logic [16:0] observe();
      return {bus.digit, bus.digit_last, bus.minor_idx, bus.stage_fetch, bus.stage_opnd,
              bus.stage_exec, bus.busy, bus.halted, bus.order_done};
   endfunction

   // One minor cycle (or its first ndig digits) of expected behaviour for stage e.
   task automatic sim_minor(input xs_t e, input bit done, input bit sp, input int ndig);
      logic [16:0] exp;
      logic [5:0]  dg;
      logic [3:0]  mn;
      for (int d = 0; d < ndig; d++) begin
         dg  = 6'(d);
         mn  = 4'(cur % 16);
         exp = {dg, d == 35, mn, e == X_FETCH, e == X_OPND, e == X_EXEC,
                e inside {X_WAIT, X_FETCH, X_OPND, X_EXEC}, e == X_HALT, done && (d == 35)};
         check("cycle", observe(), exp);
         bus.stop_req = sp && (d == 10);
         @(negedge clk);
      end
      if (ndig == 36) cur++;
   endtask

   // Runs one order from the start of its slot wait; sp_where: 0 none, 1 during FETCH, 2 first EXEC.
   task automatic do_order(input bit nd, input logic [3:0] ps, input logic [4:0] el, input bit hz,
                           input int sp_where, input logic [3:0] nos, output int res);
      int ww;
      int n;
      bus.need_opnd  = nd;
      bus.opnd_slot  = ps;
      bus.exec_len   = el;
      bus.halt_order = hz;
      ww = (int'(bus.order_slot) + 16 - cur % 16) % 16;
      repeat (ww) sim_minor(X_WAIT, 1'b0, 1'b0, 36);
      sim_minor(X_FETCH, 1'b0, sp_where == 1, 36);
      bus.order_slot = nos;
      bus.need_opnd  = 1'($urandom_range(0, 1));
      bus.opnd_slot  = 4'($urandom_range(0, 15));
      bus.exec_len   = 5'($urandom_range(0, 31));
      bus.halt_order = 1'($urandom_range(0, 1));
      if (nd) begin
         ww = (int'(ps) + 16 - cur % 16) % 16;
         repeat (ww) sim_minor(X_WAIT, 1'b0, 1'b0, 36);
         sim_minor(X_OPND, 1'b0, 1'b0, 36);
      end
      n = (el == 5'd0) ? 1 : int'(el);
      for (int i = 0; i < n; i++) sim_minor(X_EXEC, i == n - 1, (sp_where == 2) && (i == 0), 36);
      res = hz ? 2 : ((sp_where != 0 || bus.single_step) ? 1 : 0);
   endtask

   task automatic settle(input int res);
      if (res == 1) begin
         sim_minor(X_IDLE, 1'b0, 1'($urandom_range(0, 1)), 36);
      end else if (res == 2) begin
         sim_minor(X_HALT, 1'b0, 1'b1, 36);
         bus.run = 1'b0;
         sim_minor(X_HALT, 1'b0, 1'b0, 36);
         bus.run = 1'b1;
         sim_minor(X_HALT, 1'b0, 1'b0, 36);
      end
   endtask

   initial begin
      bus.run         = 1'b0;
      bus.stop_req    = 1'b0;
      bus.single_step = 1'b0;
      bus.order_slot  = 4'd5;
      bus.need_opnd   = 1'b0;
      bus.opnd_slot   = 4'd0;
      bus.exec_len    = 5'd0;
      bus.halt_order  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", observe(), 17'h0);
      rst = 1'b0;
      cur = 0;

      // Free-running counters through a full major cycle with run low.
      repeat (16) sim_minor(X_IDLE, 1'b0, 1'b0, 36);

      // Run raised in minor 0; order in slot 5, no operand, two execute minors.
      bus.run = 1'b1;
      sim_minor(X_IDLE, 1'b0, 1'b0, 36);
      do_order(1'b0, 4'd0, 5'd2, 1'b0, 0, 4'd5, after);
      settle(after);

      // Operand in slot 3 behind an order in slot 5; exec_len 0 runs one minor.
      do_order(1'b1, 4'd3, 5'd0, 1'b0, 0, 4'd5, after);
      settle(after);

      // Operand in the slot right after FETCH: no operand wait.
      do_order(1'b1, 4'd6, 5'd0, 1'b0, 0, 4'd9, after);
      settle(after);

      // Stop request in the first of three execute minors, then single-step orders.
      do_order(1'b0, 4'd0, 5'd3, 1'b0, 2, 4'd2, after);
      settle(after);
      bus.single_step = 1'b1;
      do_order(1'b1, 4'd12, 5'd1, 1'b0, 0, 4'd7, after);
      settle(after);
      do_order(1'b0, 4'd0, 5'd4, 1'b0, 0, 4'd11, after);
      settle(after);
      bus.single_step = 1'b0;

      // Stop order, halt, restart on a fresh run rising edge.
      do_order(1'b0, 4'd0, 5'd1, 1'b1, 0, 4'd3, after);
      settle(after);

      // Reset in the middle of a FETCH minor at digit 17.
      w = (int'(bus.order_slot) + 16 - cur % 16) % 16;
      repeat (w) sim_minor(X_WAIT, 1'b0, 1'b0, 36);
      sim_minor(X_FETCH, 1'b0, 1'b0, 17);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid", observe(), 17'h0);
      rst = 1'b0;
      cur = 0;
      sim_minor(X_IDLE, 1'b0, 1'b0, 36);

      // Randomized orders.
      for (int k = 0; k < 16; k++) begin
         int sp;
         sp = int'($urandom_range(0, 4));
         if (sp > 2) sp = 0;
         bus.single_step = ($urandom_range(0, 3) == 0);
         do_order(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 4)),
                  ($urandom_range(0, 7) == 0), sp, 4'($urandom_range(0, 15)), after);
         settle(after);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
